// File: rtl/mem_access_stage.sv
`timescale 1ns/1ps
// MEM stage: drives the multi-cycle data memory over a req/ack handshake, stalls upstream
// while an access is outstanding, and issues BTB update writes. Optional: MEM_ACCESS_STALL_CNT_EN.
module mem_access_stage #(
    parameter int MAX_WAIT = 16
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        EX_MEM_RegWrite,
    input  logic        EX_MEM_MemtoReg,
    input  logic        EX_MEM_MemWrite,
    input  logic        EX_MEM_MemRead,
    input  logic        EX_MEM_Branch,
    input  logic        EX_MEM_Super,
    input  logic [31:0] EX_MEM_ALUResult,
    input  logic [31:0] EX_MEM_ForwardMuxB,
    input  logic [4:0]  EX_MEM_RegDst,
    input  logic [31:0] EX_MEM_Update,
    output logic        DMem_Req,
    output logic        DMem_We,
    output logic [31:0] DMem_Addr,
    output logic [31:0] DMem_WData,
    input  logic        DMem_Ack,
    input  logic [31:0] DMem_RData,
    output logic        MemStall,
    output logic        MemErr,
    output logic        BTB_WrEn,
    output logic [31:0] BTB_WrData,
`ifdef MEM_ACCESS_STALL_CNT_EN
    output logic [31:0] StallCount,
`endif
    output logic        MEM_WB_RegWrite,
    output logic        MEM_WB_MemtoReg,
    output logic        MEM_WB_Super,
    output logic [31:0] MEM_WB_ReadData,
    output logic [31:0] MEM_WB_ALUResult,
    output logic [4:0]  MEM_WB_RegDst
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

    state_t      state, state_nxt;
    logic [7:0]  wait_cnt;
    logic        acc;
    logic        timeout_hit;
    logic        ack_hit;
    logic        btb_fire;

    logic        hold_regwrite_p1;
    logic        hold_memtoreg_p1;
    logic        hold_super_p1;
    logic [4:0]  hold_regdst_p1;
    logic [31:0] hold_alu_p1;

    assign acc = EX_MEM_MemRead | EX_MEM_MemWrite;

    always_ff @(posedge Clk) begin
        if (Rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (acc) state_nxt = S_WAIT;
            S_WAIT: if (ack_hit || timeout_hit) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ack_hit     = (state == S_WAIT) && DMem_Ack;
        timeout_hit = (state == S_WAIT) && !DMem_Ack && (wait_cnt == LAST_CNT);
        btb_fire    = (state == S_IDLE) && EX_MEM_Branch && !acc;
        MemStall    = !Rst && (((state == S_IDLE) && acc) ||
                               ((state == S_WAIT) && !DMem_Ack && !timeout_hit));
    end

    // Stage boundary: EX/MEM -> memory request / MEM/WB register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            DMem_Req         <= 1'b0;
            DMem_We          <= 1'b0;
            DMem_Addr        <= '0;
            DMem_WData       <= '0;
            wait_cnt         <= '0;
            MemErr           <= 1'b0;
            BTB_WrEn         <= 1'b0;
            BTB_WrData       <= '0;
            hold_regwrite_p1 <= 1'b0;
            hold_memtoreg_p1 <= 1'b0;
            hold_super_p1    <= 1'b0;
            hold_regdst_p1   <= '0;
            hold_alu_p1      <= '0;
            MEM_WB_RegWrite  <= 1'b0;
            MEM_WB_MemtoReg  <= 1'b0;
            MEM_WB_Super     <= 1'b0;
            MEM_WB_ReadData  <= '0;
            MEM_WB_ALUResult <= '0;
            MEM_WB_RegDst    <= '0;
        end else begin
            BTB_WrEn <= btb_fire;
            if (btb_fire) BTB_WrData <= EX_MEM_Update;

            // Bubble by default; only pass-through and ack retire real results
            MEM_WB_RegWrite  <= 1'b0;
            MEM_WB_MemtoReg  <= 1'b0;
            MEM_WB_Super     <= 1'b0;
            MEM_WB_ReadData  <= '0;
            MEM_WB_ALUResult <= '0;
            MEM_WB_RegDst    <= '0;

            case (state)
                S_IDLE: begin
                    wait_cnt <= '0;
                    if (acc) begin
                        DMem_Req         <= 1'b1;
                        DMem_We          <= EX_MEM_MemWrite;
                        DMem_Addr        <= EX_MEM_ALUResult;
                        DMem_WData       <= EX_MEM_ForwardMuxB;
                        hold_regwrite_p1 <= EX_MEM_RegWrite;
                        hold_memtoreg_p1 <= EX_MEM_MemtoReg;
                        hold_super_p1    <= EX_MEM_Super;
                        hold_regdst_p1   <= EX_MEM_RegDst;
                        hold_alu_p1      <= EX_MEM_ALUResult;
                    end else begin
                        MEM_WB_RegWrite  <= EX_MEM_RegWrite;
                        MEM_WB_MemtoReg  <= EX_MEM_MemtoReg;
                        MEM_WB_Super     <= EX_MEM_Super;
                        MEM_WB_ALUResult <= EX_MEM_ALUResult;
                        MEM_WB_RegDst    <= EX_MEM_RegDst;
                    end
                end
                S_WAIT: begin
                    if (ack_hit) begin
                        DMem_Req         <= 1'b0;
                        DMem_We          <= 1'b0;
                        wait_cnt         <= '0;
                        MEM_WB_RegWrite  <= hold_regwrite_p1;
                        MEM_WB_MemtoReg  <= hold_memtoreg_p1;
                        MEM_WB_Super     <= hold_super_p1;
                        MEM_WB_ALUResult <= hold_alu_p1;
                        MEM_WB_RegDst    <= hold_regdst_p1;
                        MEM_WB_ReadData  <= DMem_We ? 32'h0 : DMem_RData;
                    end else if (timeout_hit) begin
                        DMem_Req <= 1'b0;
                        DMem_We  <= 1'b0;
                        wait_cnt <= '0;
                        MemErr   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    DMem_Req <= 1'b0;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

`ifdef MEM_ACCESS_STALL_CNT_EN
    always_ff @(posedge Clk) begin
        if (Rst)
            StallCount <= '0;
        else if (MemStall && (StallCount != 32'hFFFF_FFFF))
            StallCount <= StallCount + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
`timescale 1ns/1ps
// Directed, table-driven bench for mem_access_stage (MAX_WAIT=4 to keep the timeout short).
module tb_mem_access_stage;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        EX_MEM_RegWrite, EX_MEM_MemtoReg, EX_MEM_MemWrite;
    logic        EX_MEM_MemRead, EX_MEM_Branch, EX_MEM_Super;
    logic [31:0] EX_MEM_ALUResult, EX_MEM_ForwardMuxB, EX_MEM_Update;
    logic [4:0]  EX_MEM_RegDst;
    logic        DMem_Req, DMem_We, DMem_Ack;
    logic [31:0] DMem_Addr, DMem_WData, DMem_RData;
    logic        MemStall, MemErr, BTB_WrEn;
    logic [31:0] BTB_WrData;
    logic        MEM_WB_RegWrite, MEM_WB_MemtoReg, MEM_WB_Super;
    logic [31:0] MEM_WB_ReadData, MEM_WB_ALUResult;
    logic [4:0]  MEM_WB_RegDst;

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    mem_access_stage #(.MAX_WAIT(4)) dut (
        .Clk(Clk), .Rst(Rst),
        .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_MemtoReg(EX_MEM_MemtoReg),
        .EX_MEM_MemWrite(EX_MEM_MemWrite), .EX_MEM_MemRead(EX_MEM_MemRead),
        .EX_MEM_Branch(EX_MEM_Branch), .EX_MEM_Super(EX_MEM_Super),
        .EX_MEM_ALUResult(EX_MEM_ALUResult), .EX_MEM_ForwardMuxB(EX_MEM_ForwardMuxB),
        .EX_MEM_RegDst(EX_MEM_RegDst), .EX_MEM_Update(EX_MEM_Update),
        .DMem_Req(DMem_Req), .DMem_We(DMem_We), .DMem_Addr(DMem_Addr),
        .DMem_WData(DMem_WData), .DMem_Ack(DMem_Ack), .DMem_RData(DMem_RData),
        .MemStall(MemStall), .MemErr(MemErr),
        .BTB_WrEn(BTB_WrEn), .BTB_WrData(BTB_WrData),
        .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_MemtoReg(MEM_WB_MemtoReg),
        .MEM_WB_Super(MEM_WB_Super), .MEM_WB_ReadData(MEM_WB_ReadData),
        .MEM_WB_ALUResult(MEM_WB_ALUResult), .MEM_WB_RegDst(MEM_WB_RegDst)
    );

    // ctl = {RegWrite, MemtoReg, MemWrite, MemRead, Branch, Super}; e_wb = {RegWrite, MemtoReg, Super}
    typedef struct packed {
        logic [5:0]  ctl;
        logic [31:0] alu;
        logic [31:0] fmb;
        logic [4:0]  dst;
        logic [31:0] upd;
        logic        ack;
        logic [31:0] rdata;
        logic        e_stall;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [2:0]  e_wb;
        logic [31:0] e_rd;
        logic [31:0] e_alu;
        logic [4:0]  e_dst;
        logic        e_btb;
        logic [31:0] e_bdata;
        logic        e_err;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] ctl, input logic [31:0] alu, input logic [31:0] fmb,
                         input logic [4:0] dst, input logic [31:0] upd,
                         input logic ack, input logic [31:0] rdata);
        {EX_MEM_RegWrite, EX_MEM_MemtoReg, EX_MEM_MemWrite,
         EX_MEM_MemRead, EX_MEM_Branch, EX_MEM_Super} = ctl;
        EX_MEM_ALUResult   = alu;
        EX_MEM_ForwardMuxB = fmb;
        EX_MEM_RegDst      = dst;
        EX_MEM_Update      = upd;
        DMem_Ack           = ack;
        DMem_RData         = rdata;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        vt[0]  = '{6'b100000, 32'hA5, 32'h0, 5'd9, 32'h0, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b100, 32'h0, 32'hA5, 5'd9, 1'b0, 32'h0, 1'b0};
        vt[1]  = '{6'b110100, 32'h40, 32'h0, 5'd5, 32'h0, 1'b0, 32'h0,
                   1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0};
        vt[2]  = vt[1];
        vt[3]  = vt[1];
        vt[4]  = '{6'b110100, 32'h40, 32'h0, 5'd5, 32'h0, 1'b1, 32'hDEADBEEF,
                   1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 3'b110, 32'hDEADBEEF, 32'h40, 5'd5, 1'b0, 32'h0, 1'b0};
        vt[5]  = '{6'b001000, 32'h80, 32'h12345678, 5'd0, 32'h0, 1'b0, 32'h0,
                   1'b1, 1'b1, 1'b1, 32'h80, 32'h12345678, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0};
        vt[6]  = '{6'b001000, 32'h80, 32'h12345678, 5'd0, 32'h0, 1'b1, 32'hFFFFFFFF,
                   1'b0, 1'b0, 1'b0, 32'h80, 32'h12345678, 3'b000, 32'h0, 32'h80, 5'd0, 1'b0, 32'h0, 1'b0};
        vt[7]  = '{6'b000010, 32'h0, 32'h0, 5'd0, 32'h00400010, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b0, 32'h80, 32'h12345678, 3'b000, 32'h0, 32'h0, 5'd0, 1'b1, 32'h00400010, 1'b0};
        vt[8]  = '{6'b000000, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1, 32'h55,
                   1'b0, 1'b0, 1'b0, 32'h80, 32'h12345678, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 32'h00400010, 1'b0};
        vt[9]  = '{6'b000110, 32'h44, 32'h0, 5'd0, 32'h11111111, 1'b0, 32'h0,
                   1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 32'h00400010, 1'b0};
        vt[10] = vt[9];
        vt[11] = vt[9];
        vt[12] = vt[9];
        vt[13] = vt[9];
        vt[13].e_stall = 1'b0;
        vt[13].e_req   = 1'b0;
        vt[13].e_err   = 1'b1;
        vt[14] = '{6'b000000, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1, 32'h99,
                   1'b0, 1'b0, 1'b0, 32'h44, 32'h0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 32'h00400010, 1'b1};
        vt[15] = '{6'b100001, 32'h7, 32'h0, 5'd31, 32'h0, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b0, 32'h44, 32'h0, 3'b101, 32'h0, 32'h7, 5'd31, 1'b0, 32'h00400010, 1'b1};

        // Reset with a pending access on the inputs: stall must stay low
        Rst = 1'b1;
        drive(6'b000100, 32'h40, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("reset_stall", MemStall, 0);
        tick();
        tick();
        chk("reset_req", DMem_Req, 0);
        chk("reset_wb", {MEM_WB_RegWrite, MEM_WB_MemtoReg, MEM_WB_Super}, 0);
        chk("reset_wb_alu", MEM_WB_ALUResult, 0);
        chk("reset_btb", BTB_WrEn, 0);
        chk("reset_err", MemErr, 0);
        drive(6'b000000, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0);
        Rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(vt[i].ctl, vt[i].alu, vt[i].fmb, vt[i].dst, vt[i].upd, vt[i].ack, vt[i].rdata);
            #1;
            chk($sformatf("v%0d_stall", i), MemStall, vt[i].e_stall);
            tick();
            chk($sformatf("v%0d_req", i), DMem_Req, vt[i].e_req);
            chk($sformatf("v%0d_we", i), DMem_We, vt[i].e_we);
            chk($sformatf("v%0d_addr", i), DMem_Addr, vt[i].e_addr);
            chk($sformatf("v%0d_wdata", i), DMem_WData, vt[i].e_wdata);
            chk($sformatf("v%0d_wbctl", i), {MEM_WB_RegWrite, MEM_WB_MemtoReg, MEM_WB_Super}, vt[i].e_wb);
            chk($sformatf("v%0d_rdata", i), MEM_WB_ReadData, vt[i].e_rd);
            chk($sformatf("v%0d_alu", i), MEM_WB_ALUResult, vt[i].e_alu);
            chk($sformatf("v%0d_dst", i), MEM_WB_RegDst, vt[i].e_dst);
            chk($sformatf("v%0d_btb", i), BTB_WrEn, vt[i].e_btb);
            chk($sformatf("v%0d_bdata", i), BTB_WrData, vt[i].e_bdata);
            chk($sformatf("v%0d_err", i), MemErr, vt[i].e_err);
        end

        // Reset in the second WAIT cycle clears the access and the sticky error
        drive(6'b110100, 32'h40, 32'h0, 5'd5, 32'h0, 1'b0, 32'h0);
        tick();
        tick();
        chk("rstw_req_before", DMem_Req, 1);
        Rst = 1'b1;
        drive(6'b000000, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("rstw_stall", MemStall, 0);
        tick();
        chk("rstw_req", DMem_Req, 0);
        chk("rstw_wb", {MEM_WB_RegWrite, MEM_WB_MemtoReg, MEM_WB_Super}, 0);
        chk("rstw_err", MemErr, 0);
        Rst = 1'b0;
        drive(6'b000000, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1, 32'hCAFE);
        #1;
        chk("rstw_ack_stall", MemStall, 0);
        tick();
        chk("rstw_ack_wb", MEM_WB_RegWrite, 0);
        chk("rstw_ack_rd", MEM_WB_ReadData, 0);
        chk("rstw_ack_req", DMem_Req, 0);

        // Back-to-back loads: request drops for one cycle between them
        drive(6'b110100, 32'h100, 32'h0, 5'd3, 32'h0, 1'b0, 32'h0);
        tick();
        chk("b2b_req1", DMem_Req, 1);
        drive(6'b110100, 32'h100, 32'h0, 5'd3, 32'h0, 1'b1, 32'hA1);
        tick();
        chk("b2b_gap", DMem_Req, 0);
        chk("b2b_rd1", MEM_WB_ReadData, 32'hA1);
        drive(6'b110100, 32'h104, 32'h0, 5'd4, 32'h0, 1'b0, 32'h0);
        #1;
        chk("b2b_stall2", MemStall, 1);
        tick();
        chk("b2b_req2", DMem_Req, 1);
        chk("b2b_addr2", DMem_Addr, 32'h104);
        drive(6'b110100, 32'h104, 32'h0, 5'd4, 32'h0, 1'b1, 32'hB2);
        tick();
        chk("b2b_rd2", MEM_WB_ReadData, 32'hB2);
        chk("b2b_dst2", MEM_WB_RegDst, 5'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
